sram_port_arbiter: RTL and testbench

//  Shares the single-port SRAM (A/D/Q/w) between two requesters: port 0 is the
//  ALU accumulator store/load path; port 1 is the host/test access path.

---
 rtl/sram_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_sram_port_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: two-port req/ack arbiter in front of a single-port SRAM.
// Port 0 is the ALU load/store path and port 1 is the host/test path.
// The SRAM address, data and write-enable are driven from registers.
// Ports:
//   clk, reset                       clock; asynchronous active-high reset
//   req/we/addr/wdata/ack (0 and 1)  per-port request and completion pulse
//   rdata                            read data, valid while ack0|ack1
//   sram_a/sram_d/sram_w/sram_q      SRAM interface
//   busy, gnt_id, proto_err          status outputs
module sram_port_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int FIXED_PRI = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_d,
  output logic          sram_w,
  input  logic [DW-1:0] sram_q,
  output logic          busy,
  output logic          gnt_id,
  output logic          proto_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic          last_grant;
  logic          any_req;
  logic          win;
  logic          g_req;
  logic          g_we;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;

  assign any_req = req0 | req1;

  always_comb begin
    win = 1'b0;
    if (FIXED_PRI != 0)
      win = !req0;
    else if (req0 && req1)
      win = !last_grant;
    else
      win = !req0;
  end

  // Live inputs of the port that owns the current transaction.
  always_comb begin
    g_req   = gnt_id ? req1   : req0;
    g_we    = gnt_id ? we1    : we0;
    g_addr  = gnt_id ? addr1  : addr0;
    g_wdata = gnt_id ? wdata1 : wdata0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    rdata     = '0;
    case (state)
      IDLE: begin
        if (any_req)
          state_nxt = ACCESS;
      end
      ACCESS: begin
        busy      = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        busy      = 1'b1;
        ack0      = !gnt_id;
        ack1      = gnt_id;
        rdata     = sram_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sram_a     <= '0;
      sram_d     <= '0;
      sram_w     <= 1'b0;
      gnt_id     <= 1'b0;
      last_grant <= 1'b1;
      proto_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            sram_a     <= win ? addr1  : addr0;
            sram_d     <= win ? wdata1 : wdata0;
            sram_w     <= win ? we1    : we0;
            gnt_id     <= win;
            last_grant <= win;
          end
        end
        ACCESS: begin
          sram_w <= 1'b0;
          // sram_a/d/w still hold the captured request here, so they double as the reference.
          if (!g_req || g_addr != sram_a || g_wdata != sram_d || g_we != sram_w)
            proto_err <= 1'b1;
        end
        RESP: begin
          if (!g_req)
            proto_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

  logic       clk;
  logic       reset;
  logic       req0, we0, req1, we1;
  logic [7:0] addr0, wdata0, addr1, wdata1;

  logic       d0_ack0, d0_ack1, d0_sram_w, d0_busy, d0_gnt_id, d0_proto_err;
  logic [7:0] d0_rdata, d0_sram_a, d0_sram_d, d0_sram_q;
  logic       d1_ack0, d1_ack1, d1_sram_w, d1_busy, d1_gnt_id, d1_proto_err;
  logic [7:0] d1_rdata, d1_sram_a, d1_sram_d, d1_sram_q;

  logic [7:0] mem0 [0:255];
  logic [7:0] mem1 [0:255];

  int n_total;
  int n_bad;

  sram_port_arbiter #(.AW(8), .DW(8), .FIXED_PRI(0)) dut_rr (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(d0_ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(d0_ack1),
    .rdata(d0_rdata), .sram_a(d0_sram_a), .sram_d(d0_sram_d), .sram_w(d0_sram_w),
    .sram_q(d0_sram_q), .busy(d0_busy), .gnt_id(d0_gnt_id), .proto_err(d0_proto_err)
  );

  sram_port_arbiter #(.AW(8), .DW(8), .FIXED_PRI(1)) dut_fp (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(d1_ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(d1_ack1),
    .rdata(d1_rdata), .sram_a(d1_sram_a), .sram_d(d1_sram_d), .sram_w(d1_sram_w),
    .sram_q(d1_sram_q), .busy(d1_busy), .gnt_id(d1_gnt_id), .proto_err(d1_proto_err)
  );

  always @(posedge clk) begin
    if (d0_sram_w) mem0[d0_sram_a] <= d0_sram_d;
    d0_sram_q <= mem0[d0_sram_a];
  end

  always @(posedge clk) begin
    if (d1_sram_w) mem1[d1_sram_a] <= d1_sram_d;
    d1_sram_q <= mem1[d1_sram_a];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a negedge with the arbiter idle; returns at a negedge with req dropped.
  task automatic txn(input int p, input logic w, input logic [7:0] a, input logic [7:0] d,
                     output logic [7:0] rd);
    int   n;
    logic seen;
    n    = 0;
    seen = 1'b0;
    rd   = 'x;
    if (p == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    while (!seen && n < 10) begin
      @(negedge clk);
      n++;
      if ((p == 0) ? d0_ack0 : d0_ack1) begin
        seen = 1'b1;
        rd   = d0_rdata;
      end
    end
    chk("txn_latency", n, 2);
    @(negedge clk);
    chk("txn_ack_pulse", (p == 0) ? d0_ack0 : d0_ack1, 0);
    if (p == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  initial begin
    logic [7:0] rd;
    int k;
    n_total = 0;
    n_bad   = 0;
    we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    do_reset();

    // reset state
    chk("rst_ack0", d0_ack0, 0);
    chk("rst_ack1", d0_ack1, 0);
    chk("rst_sram_w", d0_sram_w, 0);
    chk("rst_busy", d0_busy, 0);
    chk("rst_gnt", d0_gnt_id, 0);
    chk("rst_perr", d0_proto_err, 0);
    chk("rst_sram_a", d0_sram_a, 0);
    chk("rst_sram_d", d0_sram_d, 0);
    chk("rst_rdata", d0_rdata, 0);

    // 1: port0 write 0xA5 @0x12, port1 reads it back
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h12; wdata0 = 8'hA5;
    @(negedge clk);
    chk("t1_acc_w", d0_sram_w, 1);
    chk("t1_acc_a", d0_sram_a, 8'h12);
    chk("t1_acc_d", d0_sram_d, 8'hA5);
    chk("t1_acc_busy", d0_busy, 1);
    chk("t1_acc_gnt", d0_gnt_id, 0);
    chk("t1_acc_ack", d0_ack0, 0);
    @(negedge clk);
    chk("t1_resp_ack0", d0_ack0, 1);
    chk("t1_resp_w", d0_sram_w, 0);
    chk("t1_resp_busy", d0_busy, 1);
    @(negedge clk);
    chk("t1_idle_ack0", d0_ack0, 0);
    chk("t1_idle_busy", d0_busy, 0);
    req0 = 1'b0;
    txn(1, 1'b0, 8'h12, 8'h00, rd);
    chk("t1_rdata", rd, 8'hA5);
    chk("t1_gnt1", d0_gnt_id, 1);
    chk("t1_perr", d0_proto_err, 0);

    // 2/3: both requesting continuously; round-robin vs fixed priority
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h01;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h02;
    k = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (d0_ack0 || d0_ack1) begin
        chk("t2_ack_cycle", i, 3 * k + 2);
        chk("t2_ack_port", d0_ack1, k % 2);
        k++;
      end
      chk("t3_no_ack1", d1_ack1, 0);
      chk("t3_ack0", d1_ack0, (i % 3 == 2) ? 1 : 0);
    end
    chk("t2_ack_count", k, 4);
    chk("t2_perr", d0_proto_err, 0);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);

    // 4: reset during a write ACCESS
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h40; wdata0 = 8'h77;
    @(negedge clk);
    chk("t4_acc_w", d0_sram_w, 1);
    chk("t4_acc_busy", d0_busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("t4_rst_w", d0_sram_w, 0);
    chk("t4_rst_busy", d0_busy, 0);
    chk("t4_rst_ack", d0_ack0, 0);
    chk("t4_rst_perr", d0_proto_err, 0);
    @(negedge clk);
    reset = 1'b0; req0 = 1'b0;
    @(negedge clk);
    chk("t4_idle_busy", d0_busy, 0);
    chk("t4_idle_ack", d0_ack0, 0);

    // Rewrite 0x12 (reset may have disturbed nothing, but keep test 5 self-contained)
    txn(0, 1'b1, 8'h12, 8'hA5, rd);

    // 5: port1 drops req1 during RESP
    chk("t5_perr_pre", d0_proto_err, 0);
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h12;
    @(negedge clk);
    @(negedge clk);
    chk("t5_ack1", d0_ack1, 1);
    chk("t5_rdata", d0_rdata, 8'hA5);
    req1 = 1'b0;
    @(negedge clk);
    chk("t5_perr_set", d0_proto_err, 1);
    chk("t5_ack1_off", d0_ack1, 0);
    txn(0, 1'b0, 8'h12, 8'h00, rd);
    chk("t5_perr_sticky", d0_proto_err, 1);
    do_reset();
    chk("t5_perr_clr", d0_proto_err, 0);

    // address change during ACCESS
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h12;
    @(negedge clk);
    addr0 = 8'h13;
    @(negedge clk);
    chk("tx_ack0", d0_ack0, 1);
    chk("tx_rdata", d0_rdata, 8'hA5);
    chk("tx_perr", d0_proto_err, 1);
    @(negedge clk);
    req0 = 1'b0;
    do_reset();

    // 6: address extremes, no aliasing
    txn(0, 1'b1, 8'h00, 8'h11, rd);
    txn(1, 1'b1, 8'hFF, 8'h3C, rd);
    txn(0, 1'b0, 8'h00, 8'h00, rd);
    chk("t6_rd_00", rd, 8'h11);
    txn(1, 1'b0, 8'hFF, 8'h00, rd);
    chk("t6_rd_ff", rd, 8'h3C);
    chk("t6_perr", d0_proto_err, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
